imem_loader: RTL and testbench

//  Write-side companion to the byte-addressed, little-endian instruction ROM.

---
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into the instruction memory as 32-bit
// little-endian words, using byte enables for a trailing partial word.
module imem_loader #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter logic [31:0] BASE_ADDR     = 32'h0,
   parameter int unsigned MEM_BYTES     = 65536
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic [3:0]               mem_be,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [2:0]               dbg_state
);

   // Handshake: a byte moves on a rising edge where rx_valid && rx_ready;
   // rx_ready is a function of state alone (high only in LEN and DATA).
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Capacity left above the base; 33 bits so N up to 2^32-1 compares cleanly.
   localparam logic [32:0] CAPACITY = 33'(MEM_BYTES) - 33'(BASE_ADDR);

   state_t                   r_state;
   state_t                   w_next;
   logic [31:0]              r_len;
   logic [31:0]              r_cnt;
   logic [1:0]               r_lidx;
   logic [ADDRESS_WIDTH-3:0] r_widx;
   logic [DATA_WIDTH-1:0]    r_buf;
   logic [3:0]               r_be;
   logic                     r_error;

   logic                     w_take;
   logic                     w_start;
   logic [31:0]              w_len_full;
   logic                     w_len_over;
   logic [31:0]              w_cnt_inc;
   logic                     w_word_last;

   assign w_take      = rx_valid && rx_ready;
   assign w_start     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_len_full  = {rx_data, r_len[31:8]};
   assign w_len_over  = {1'b0, w_len_full} > CAPACITY;
   assign w_cnt_inc   = r_cnt + 32'd1;
   assign w_word_last = (r_cnt[1:0] == 2'd3) || (w_cnt_inc == r_len);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_next = S_LEN;
         S_LEN: begin
            if (w_take && (r_lidx == 2'd3)) begin
               if ((w_len_full == 32'd0) || w_len_over) w_next = S_DONE;
               else                                    w_next = S_DATA;
            end
         end
         S_DATA:  if (w_take && w_word_last) w_next = S_WRITE;
         S_WRITE: w_next = (r_cnt == r_len) ? S_DONE : S_DATA;
         S_DONE:  if (w_start) w_next = S_LEN;
         default: w_next = S_IDLE;
      endcase
   end

   // Address/data/enables are gated to zero outside WRITE so idle outputs stay quiet.
   always_comb begin
      rx_ready  = (r_state == S_LEN) || (r_state == S_DATA);
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = 4'b0000;
      if (r_state == S_WRITE) begin
         mem_we    = 1'b1;
         mem_addr  = ADDRESS_WIDTH'(BASE_ADDR) + {r_widx, 2'b00};
         mem_wdata = r_buf;
         mem_be    = r_be;
      end
      busy      = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_WRITE);
      done      = (r_state == S_DONE);
      error     = r_error;
      dbg_state = r_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_len   <= '0;
         r_cnt   <= '0;
         r_lidx  <= '0;
         r_widx  <= '0;
         r_buf   <= '0;
         r_be    <= '0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start) begin
                  r_len   <= '0;
                  r_cnt   <= '0;
                  r_lidx  <= '0;
                  r_widx  <= '0;
                  r_buf   <= '0;
                  r_be    <= '0;
                  r_error <= 1'b0;
               end
            end
            S_LEN: begin
               if (w_take) begin
                  r_len  <= w_len_full;
                  r_lidx <= r_lidx + 2'd1;
                  if ((r_lidx == 2'd3) && w_len_over) r_error <= 1'b1;
               end
            end
            S_DATA: begin
               if (w_take) begin
                  r_buf[{r_cnt[1:0], 3'b000} +: 8] <= rx_data;
                  r_be[r_cnt[1:0]]                 <= 1'b1;
                  r_cnt                            <= w_cnt_inc;
               end
            end
            S_WRITE: begin
               r_widx <= r_widx + 1'b1;
               r_buf  <= '0;
               r_be   <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte images, logs every write strobe
// and compares against hand-computed expected words.
module tb_imem_loader;

  localparam int MEM_BYTES = 65536;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [67:0] exp_q[$];
  logic [67:0] obs_q[$];
  logic [7:0]  img_q[$];

  imem_loader #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .BASE_ADDR(32'h0),
    .MEM_BYTES(MEM_BYTES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .busy(busy),
    .done(done),
    .error(error),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // write monitor: every strobe is logged; rx_ready must be low during WRITE
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_q.push_back({mem_addr, mem_wdata, mem_be});
      check_eq("rdy_in_write", 80'(rx_ready), 80'd0);
    end
  end

  // driver tasks
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    rx_data  = b;
    rx_valid = 1'b1;
    guard    = 0;
    while (!rx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_eq("ready_timeout", 80'd0, 80'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_image(input bit gaps);
    for (int i = 0; i < img_q.size(); i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        rx_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send_byte(img_q[i]);
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("done_timeout", 80'(done), 80'd1);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_q.push_back({a, d, be});
  endtask

  // scoreboard: compare logged writes against the expected queue, then clear
  task automatic check_writes(input string tag);
    int n;
    check_eq({tag, "_nwrites"}, 80'(obs_q.size()), 80'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_write"}, 80'(obs_q[i]), 80'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic load_scn1();
    img_q = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
              8'h93, 8'h05, 8'h20, 8'h00};
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset_outputs",
             80'({rx_ready, mem_we, mem_addr, mem_wdata, mem_be, busy, done, error}), 80'd0);
    check_eq("reset_state", 80'(dbg_state), 80'd0);

    // 1: two full words
    load_scn1();
    push_exp(32'h0, 32'h00100513, 4'hF);
    push_exp(32'h4, 32'h00200593, 4'hF);
    pulse_start();
    check_eq("s1_busy_len", 80'({busy, rx_ready}), 80'b11);
    send_image(1'b0);
    wait_done();
    check_eq("s1_flags", 80'({done, error, busy}), 80'b100);
    check_writes("s1");

    // 2: N=5, trailing partial word
    img_q = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    push_exp(32'h0, 32'hDDCCBBAA, 4'hF);
    push_exp(32'h4, 32'h000000EE, 4'h1);
    pulse_start();
    check_eq("s2_done_cleared", 80'(done), 80'd0);
    send_image(1'b0);
    wait_done();
    check_eq("s2_flags", 80'({done, error, busy}), 80'b100);
    check_writes("s2");

    // 3: N=0, done one cycle after the 4th length byte
    img_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start();
    send_image(1'b0);
    check_eq("s3_done_next", 80'({done, error, busy}), 80'b100);
    check_writes("s3");

    // 4: N=MEM_BYTES+1, rejected without writing
    img_q = '{8'h01, 8'h00, 8'h01, 8'h00};
    pulse_start();
    send_image(1'b0);
    wait_done();
    check_eq("s4_flags", 80'({done, error, busy}), 80'b110);
    check_writes("s4");
    pulse_start();
    check_eq("s4_cleared", 80'({done, error, busy}), 80'b001);
    img_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_image(1'b0);
    wait_done();
    check_eq("s4_after_zero", 80'({done, error}), 80'b10);

    // 5: scenario 1 with valid gaps
    load_scn1();
    push_exp(32'h0, 32'h00100513, 4'hF);
    push_exp(32'h4, 32'h00200593, 4'hF);
    pulse_start();
    send_image(1'b1);
    wait_done();
    check_eq("s5_flags", 80'({done, error, busy}), 80'b100);
    check_writes("s5");

    // 6: reset mid-load, starts ignored while busy, then full reload
    img_q = '{8'h10, 8'h00, 8'h00, 8'h00};
    pulse_start();
    send_image(1'b0);
    push_exp(32'h0, 32'h13121110, 4'hF);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(8'h10 + i));
      if (i == 1 || i == 3) begin
        rx_valid = 1'b0;
        pulse_start();
        check_eq("s6_busy_after_start", 80'({busy, done}), 80'b10);
      end
    end
    rx_valid = 1'b0;
    check_eq("s6_state_data", 80'(dbg_state), 80'd2);
    rst = 1'b1;
    @(negedge clk);
    check_eq("s6_reset_outputs",
             80'({rx_ready, mem_we, mem_addr, mem_wdata, mem_be, busy, done, error}), 80'd0);
    rst = 1'b0;
    check_writes("s6a");

    img_q = '{8'h10, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) img_q.push_back(8'(8'h10 + i));
    push_exp(32'h0, 32'h13121110, 4'hF);
    push_exp(32'h4, 32'h17161514, 4'hF);
    push_exp(32'h8, 32'h1B1A1918, 4'hF);
    push_exp(32'hC, 32'h1F1E1D1C, 4'hF);
    pulse_start();
    send_image(1'b0);
    wait_done();
    check_eq("s6_flags", 80'({done, error, busy}), 80'b100);
    check_writes("s6b");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
